// File: rtl/write_back_stage.sv
// Write-back stage: registers the DM-stage result, commits it to an embedded
// register file, and serves two read ports with write-through bypass.
module write_back_stage #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] ans_dm,
    input  logic [DATA_W-1:0] ans_alu,
    input  logic              wb_sel,
    input  logic [ADDR_W-1:0] rd_dm,
    input  logic              we_dm,
    input  logic              stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic [DATA_W-1:0] ans_wb,
    output logic [ADDR_W-1:0] rd_wb,
    output logic              we_wb,
    output logic [CNT_W-1:0]  wb_count
);

    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [NREG];
    logic              wr_allowed;

    assign wr_allowed = !((ZERO_REG != 0) && (rd_wb == '0));

    always_ff @(posedge clk) begin
        if (reset) begin
            ans_wb   <= '0;
            rd_wb    <= '0;
            we_wb    <= 1'b0;
            wb_count <= '0;
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            // The entry already in WB retires regardless of flush/stall.
            if (we_wb) begin
                wb_count <= wb_count + CNT_W'(1);
                if (wr_allowed) begin
                    regs[rd_wb] <= ans_wb;
                end
            end
            if (flush) begin
                ans_wb <= '0;
                rd_wb  <= '0;
                we_wb  <= 1'b0;
            end else if (stall) begin
                we_wb  <= 1'b0;
            end else begin
                ans_wb <= wb_sel ? ans_dm : ans_alu;
                rd_wb  <= rd_dm;
                we_wb  <= we_dm;
            end
        end
    end

    assign rd1 = ((ZERO_REG != 0) && (ra1 == '0)) ? '0 :
                 (we_wb && (rd_wb == ra1))        ? ans_wb : regs[ra1];
    assign rd2 = ((ZERO_REG != 0) && (ra2 == '0)) ? '0 :
                 (we_wb && (rd_wb == ra2))        ? ans_wb : regs[ra2];

endmodule

// File: tb/tb_write_back_stage.sv
// Self-checking bench for write_back_stage: directed scenarios with literal
// expectations plus randomized traffic compared against a behavioural model.
module tb_write_back_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] ans_dm = '0, ans_alu = '0;
    logic        wb_sel = 1'b0, we_dm = 1'b0, stall = 1'b0, flush = 1'b0;
    logic [2:0]  rd_dm = '0, ra1 = '0, ra2 = '0;
    logic [15:0] rd1, rd2, ans_wb;
    logic [2:0]  rd_wb;
    logic        we_wb;
    logic [3:0]  wb_count;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    write_back_stage #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .ans_dm(ans_dm), .ans_alu(ans_alu),
        .wb_sel(wb_sel), .rd_dm(rd_dm), .we_dm(we_dm), .stall(stall),
        .flush(flush), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .ans_wb(ans_wb), .rd_wb(rd_wb), .we_wb(we_wb), .wb_count(wb_count)
    );

    always #5 clk = ~clk;

    // Behavioural model: register file contents, the entry sitting in WB, commit count.
    int m_regs [8];
    int m_val = 0, m_rd = 0, m_cnt = 0;
    bit m_valid = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) m_regs[i] = 0;
            m_val = 0; m_rd = 0; m_valid = 1'b0; m_cnt = 0;
        end else begin
            if (m_valid) begin
                m_cnt = (m_cnt + 1) % 16;
                if (m_rd != 0) m_regs[m_rd] = m_val;
            end
            if (flush) begin
                m_val = 0; m_rd = 0; m_valid = 1'b0;
            end else if (stall) begin
                m_valid = 1'b0;
            end else begin
                m_val = wb_sel ? int'(ans_dm) : int'(ans_alu);
                m_rd = int'(rd_dm);
                m_valid = we_dm;
            end
        end
    end

    function automatic int exp_read(input int ra);
        if (ra == 0) return 0;
        if (m_valid && m_rd == ra) return m_val;
        return m_regs[ra];
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_ans_wb", int'(ans_wb), m_val);
            check("m_rd_wb", int'(rd_wb), m_rd);
            check("m_we_wb", int'(we_wb), int'(m_valid));
            check("m_wb_count", int'(wb_count), m_cnt);
            check("m_rd1", int'(rd1), exp_read(int'(ra1)));
            check("m_rd2", int'(rd2), exp_read(int'(ra2)));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        chk_en = 1'b1;
        check("rst_count", int'(wb_count), 0);
        check("rst_we_wb", int'(we_wb), 0);

        // Basic capture and bypass
        we_dm = 1'b1; rd_dm = 3'd3; wb_sel = 1'b0; ans_alu = 16'h1234; ra1 = 3'd3;
        tick();
        check("cap_ans_wb", int'(ans_wb), 'h1234);
        check("cap_we_wb", int'(we_wb), 1);
        check("bypass_rd1", int'(rd1), 'h1234);
        we_dm = 1'b0; ra2 = 3'd3;
        tick();
        check("array_rd2", int'(rd2), 'h1234);
        check("count_1", int'(wb_count), 1);

        // Zero register
        ra1 = 3'd0; we_dm = 1'b1; rd_dm = 3'd0; wb_sel = 1'b1; ans_dm = 16'hFFFF;
        tick();
        check("zero_rd1_wb", int'(rd1), 0);
        we_dm = 1'b0;
        tick();
        check("zero_rd1_after", int'(rd1), 0);
        check("zero_count", int'(wb_count), 2);

        // Stall for 3 cycles with upstream held
        we_dm = 1'b1; rd_dm = 3'd5; wb_sel = 1'b0; ans_alu = 16'h00AA;
        tick();
        stall = 1'b1;
        tick();
        check("stall_count1", int'(wb_count), 3);
        check("stall_we_wb1", int'(we_wb), 0);
        tick(); tick();
        check("stall_count3", int'(wb_count), 3);
        check("stall_we_wb3", int'(we_wb), 0);
        check("stall_hold", int'(ans_wb), 'h00AA);
        stall = 1'b0; we_dm = 1'b0; ra1 = 3'd5;
        tick();
        check("stall_reg5", int'(rd1), 'h00AA);

        // Flush while a valid entry is in WB
        we_dm = 1'b1; rd_dm = 3'd2; ans_alu = 16'h0042;
        tick();
        flush = 1'b1; rd_dm = 3'd4; ans_alu = 16'hBEEF;
        tick();
        check("flush_we_wb", int'(we_wb), 0);
        check("flush_count", int'(wb_count), 4);
        flush = 1'b0; we_dm = 1'b0; ra1 = 3'd2; ra2 = 3'd4;
        tick();
        check("flush_reg2", int'(rd1), 'h0042);
        check("flush_reg4", int'(rd2), 0);

        // 17 commits wrap the 4-bit counter to 1
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 17; i++) begin
            we_dm = 1'b1; rd_dm = 3'(1 + (i % 7)); ans_alu = 16'(16'h0100 + i);
            tick();
        end
        we_dm = 1'b0;
        tick();
        check("wrap_count", int'(wb_count), 1);

        // Reset concurrent with a pending commit
        we_dm = 1'b1; rd_dm = 3'd6; ans_alu = 16'h7777;
        tick();
        check("pend_we_wb", int'(we_wb), 1);
        reset = 1'b1; we_dm = 1'b0;
        tick();
        reset = 1'b0;
        check("rst_commit_count", int'(wb_count), 0);
        check("rst_commit_we", int'(we_wb), 0);
        for (int a = 0; a < 8; a++) begin
            ra1 = 3'(a);
            #1;
            check("rst_regs_zero", int'(rd1), 0);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            reset   = ($urandom_range(0, 63) == 0);
            flush   = ($urandom_range(0, 7) == 0);
            stall   = ($urandom_range(0, 5) == 0);
            we_dm   = ($urandom_range(0, 3) != 0);
            wb_sel  = 1'($urandom);
            ans_dm  = 16'($urandom);
            ans_alu = 16'($urandom);
            rd_dm   = 3'($urandom);
            ra1     = 3'($urandom);
            ra2     = 3'($urandom);
            tick();
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
